// File: rtl/window_generator_3x3.sv
// 3x3 neighbourhood window generator: raster pixel stream in, one registered
// 3x3 window per accepted pixel once two lines and two columns of context exist.
module window_generator_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  sof,
  output logic [DATA_WIDTH-1:0] window [0:8],
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_cur_c;
  logic [ROW_W-1:0] row_cur_c;
  logic [COL_W-1:0] col_nxt_c;
  logic [ROW_W-1:0] row_nxt_c;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_rd_c;
  logic [DATA_WIDTH-1:0] lb1_rd_c;

  logic in_win_c;
  logic last_c;

  // Position of the pixel being accepted (sof forces (0,0)), its successor, and line-buffer reads
  always_comb begin
    col_cur_c = sof ? '0 : col;
    row_cur_c = sof ? '0 : row;
    col_nxt_c = col_cur_c + COL_W'(1);
    row_nxt_c = row_cur_c;
    if (col_cur_c == COL_W'(IMG_WIDTH - 1)) begin
      col_nxt_c = '0;
      row_nxt_c = (row_cur_c == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_cur_c + ROW_W'(1);
    end
    lb0_rd_c = lb0[col_cur_c];
    lb1_rd_c = lb1[col_cur_c];
    in_win_c = (row_cur_c >= ROW_W'(2)) && (col_cur_c >= COL_W'(2));
    last_c   = (row_cur_c == ROW_W'(IMG_HEIGHT - 1)) && (col_cur_c == COL_W'(IMG_WIDTH - 1));
  end

  // Raster position counters, advanced only on accepted pixels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      col <= col_nxt_c;
      row <= row_nxt_c;
    end
  end

  // Line buffers: lb1 holds line r-1, lb0 holds line r-2; stale data is hidden by position gating
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb0[col_cur_c] <= lb1_rd_c;
      lb1[col_cur_c] <= pixel_in;
    end
  end

  // Shift array: each row shifts left, the new column (r-2, r-1, r) enters on the right
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) window[i] <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= pixel_valid && in_win_c;
      frame_done   <= pixel_valid && in_win_c && last_c;
      if (pixel_valid) begin
        for (int r = 0; r < 3; r++) begin
          window[3*r]   <= window[3*r+1];
          window[3*r+1] <= window[3*r+2];
        end
        window[2] <= lb0_rd_c;
        window[5] <= lb1_rd_c;
        window[8] <= pixel_in;
      end
    end
  end

endmodule
